// File: rtl/bcd_scan_display.sv
// Three-digit multiplexed 7-segment driver: scans BCD digits with a dark gap
// between digits, with per-frame snapshot, leading-zero blanking and decimal points.
//
// state | meaning
// ------+---------------------------------------------------------------
// BLANK | all anodes off, all segments off; counting BLANK_CYC cycles
// SHOW  | anode idx on, segments for snapshot digit idx; SCAN_DIV cycles
module bcd_scan_display #(
    parameter logic [15:0] SCAN_DIV  = 16'd50000,
    parameter logic [7:0]  BLANK_CYC = 8'd64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [11:0] value,
    input  logic [2:0]  dp_sel,
    input  logic        lzb,
    output logic [7:0]  seg_n,
    output logic [2:0]  an_n,
    output logic        frame_tick
);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    localparam logic [15:0] SHOW_LAST  = SCAN_DIV - 16'd1;
    localparam logic [15:0] BLANK_LAST = {8'd0, BLANK_CYC - 8'd1};

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [1:0]  idx, idx_nxt;
    logic [11:0] snap_value, snap_value_nxt;
    logic [2:0]  snap_dp, snap_dp_nxt;
    logic        snap_lzb, snap_lzb_nxt;
    logic [7:0]  seg_nxt;
    logic [2:0]  an_nxt;
    logic        tick_nxt;
    logic [3:0]  digit;
    logic        blank;
    logic        dp_on;

    // Active-high gfedcba; anything outside 0..9 shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= BLANK;
            cnt        <= 16'd0;
            idx        <= 2'd0;
            snap_value <= 12'd0;
            snap_dp    <= 3'd0;
            snap_lzb   <= 1'b0;
            seg_n      <= 8'hFF;
            an_n       <= 3'b111;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            snap_value <= snap_value_nxt;
            snap_dp    <= snap_dp_nxt;
            snap_lzb   <= snap_lzb_nxt;
            seg_n      <= seg_nxt;
            an_n       <= an_nxt;
            frame_tick <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + 16'd1;
        idx_nxt        = idx;
        snap_value_nxt = snap_value;
        snap_dp_nxt    = snap_dp;
        snap_lzb_nxt   = snap_lzb;
        if (!en) begin
            state_nxt = BLANK;
            cnt_nxt   = 16'd0;
            idx_nxt   = 2'd0;
        end else begin
            case (state)
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nxt = SHOW;
                        cnt_nxt   = 16'd0;
                        // Frame snapshot is taken only as digit 0 lights, so a frame never tears.
                        if (idx == 2'd0) begin
                            snap_value_nxt = value;
                            snap_dp_nxt    = dp_sel;
                            snap_lzb_nxt   = lzb;
                        end
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state_nxt = BLANK;
                        cnt_nxt   = 16'd0;
                        idx_nxt   = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                    end
                end
            endcase
        end
    end

    // Outputs are computed from next-state values so they register on the transition edge.
    always_comb begin
        digit = snap_value_nxt[3:0];
        blank = 1'b0;
        dp_on = snap_dp_nxt[0];
        case (idx_nxt)
            2'd1: begin
                digit = snap_value_nxt[7:4];
                blank = snap_lzb_nxt && (snap_value_nxt[11:8] == 4'd0)
                        && (snap_value_nxt[7:4] == 4'd0);
                dp_on = snap_dp_nxt[1];
            end
            2'd2: begin
                digit = snap_value_nxt[11:8];
                blank = snap_lzb_nxt && (snap_value_nxt[11:8] == 4'd0);
                dp_on = snap_dp_nxt[2];
            end
            default: ;
        endcase

        seg_nxt  = 8'hFF;
        an_nxt   = 3'b111;
        if (state_nxt == SHOW) begin
            seg_nxt = {~dp_on, blank ? 7'h7F : ~seg_decode(digit)};
            an_nxt  = ~(3'b001 << idx_nxt);
        end
        tick_nxt = (state == BLANK) && (state_nxt == SHOW) && (idx_nxt == 2'd0);
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Bench for bcd_scan_display: table-driven digit checks, hand-written corner
// sequences and randomized traffic against a frame-position reference model.
module tb_bcd_scan_display;

    localparam int SD    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = SD + BC;
    localparam int FRAME = 3 * SLOT;

    localparam logic [6:0] SEGMAP [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk;
    logic        reset;
    logic        en;
    logic [11:0] value;
    logic [2:0]  dp_sel;
    logic        lzb;
    logic [7:0]  seg_n;
    logic [2:0]  an_n;
    logic        frame_tick;

    bcd_scan_display #(.SCAN_DIV(16'(SD)), .BLANK_CYC(8'(BC))) dut (
        .clk(clk), .reset(reset), .en(en), .value(value), .dp_sel(dp_sel),
        .lzb(lzb), .seg_n(seg_n), .an_n(an_n), .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: edges since the scan (re)started, and the frame snapshot.
    int          m_t = 0;
    logic [11:0] m_val = 12'd0;
    logic [2:0]  m_dp = 3'd0;
    logic        m_lzb = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] exp_digit(input int k);
        int d, d1, d2;
        logic blank;
        logic [6:0] s;
        d  = (int'(m_val) >> (4 * k)) % 16;
        d1 = (int'(m_val) >> 4) % 16;
        d2 = (int'(m_val) >> 8) % 16;
        blank = m_lzb && ((k == 2 && d2 == 0) || (k == 1 && d2 == 0 && d1 == 0));
        s = blank ? 7'h7F : ~((d < 10) ? SEGMAP[d] : 7'h40);
        return {((int'(m_dp) >> k) % 2 == 1) ? 1'b0 : 1'b1, s};
    endfunction

    task automatic model_reset();
        m_t = 0; m_val = 12'd0; m_dp = 3'd0; m_lzb = 1'b0;
    endtask

    task automatic step();
        logic r_e, en_e, l_e;
        logic [11:0] v_e;
        logic [2:0] dp_e;
        logic [11:0] exp;
        int p, pf;
        r_e = reset; en_e = en; v_e = value; dp_e = dp_sel; l_e = lzb;
        @(posedge clk);
        #1;
        p = -1;
        if (!r_e) model_reset();
        else if (!en_e) m_t = 0;
        else begin
            m_t++;
            p = m_t - BC;
            if (p >= 0 && p % FRAME == 0) begin
                m_val = v_e; m_dp = dp_e; m_lzb = l_e;
            end
        end
        exp = {8'hFF, 3'b111, 1'b0};
        if (p >= 0) begin
            pf = p % FRAME;
            if (pf % SLOT < SD)
                exp = {exp_digit(pf / SLOT), ~(3'b001 << (pf / SLOT)), pf == 0};
        end
        chk("scan_model", {20'd0, seg_n, an_n, frame_tick}, {20'd0, exp});
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_tick && n < budget);
        if (!frame_tick) chk("tick_timeout", 32'(n), 32'(budget + 1));
    endtask

    typedef struct {
        logic [11:0] v;
        logic [2:0]  dp;
        logic        lz;
        logic [7:0]  s0, s1, s2;
    } vec_t;

    vec_t vecs [$];

    initial begin
        int n;
        vecs.push_back('{12'h059, 3'b000, 1'b1, 8'h90, 8'h92, 8'hFF});
        vecs.push_back('{12'h000, 3'b010, 1'b0, 8'hC0, 8'h40, 8'hC0});
        vecs.push_back('{12'h0A1, 3'b000, 1'b0, 8'hF9, 8'hBF, 8'hC0});
        vecs.push_back('{12'h000, 3'b111, 1'b1, 8'h40, 8'h7F, 8'h7F});
        vecs.push_back('{12'h105, 3'b000, 1'b1, 8'h92, 8'hC0, 8'hF9});
        vecs.push_back('{12'h0F0, 3'b100, 1'b1, 8'hC0, 8'hBF, 8'h7F});
        vecs.push_back('{12'h987, 3'b001, 1'b0, 8'h78, 8'h80, 8'h90});
        vecs.push_back('{12'h234, 3'b000, 1'b1, 8'h99, 8'hB0, 8'hA4});
        vecs.push_back('{12'h006, 3'b000, 1'b1, 8'h82, 8'hFF, 8'hFF});

        reset = 1'b0; en = 1'b0; value = 12'h059; dp_sel = 3'b000; lzb = 1'b1;
        step();
        step();
        chk("reset_state", {20'd0, seg_n, an_n, frame_tick}, {20'd0, 8'hFF, 3'b111, 1'b0});

        reset = 1'b1; en = 1'b1;
        wait_tick(40, n);
        chk("first_tick_after_reset", 32'(n), 32'(BC));

        foreach (vecs[i]) begin
            value = vecs[i].v; dp_sel = vecs[i].dp; lzb = vecs[i].lz;
            en = 1'b0;
            step();
            en = 1'b1;
            wait_tick(40, n);
            chk($sformatf("vec%0d_d0", i), {21'd0, seg_n, an_n}, {21'd0, vecs[i].s0, 3'b110});
            repeat (SLOT) step();
            chk($sformatf("vec%0d_d1", i), {21'd0, seg_n, an_n}, {21'd0, vecs[i].s1, 3'b101});
            repeat (SLOT) step();
            chk($sformatf("vec%0d_d2", i), {21'd0, seg_n, an_n}, {21'd0, vecs[i].s2, 3'b011});
        end

        // Snapshot holds when value changes mid-frame.
        value = 12'h012; dp_sel = 3'b000; lzb = 1'b0;
        wait_tick(40, n);
        wait_tick(40, n);
        repeat (SLOT) step();
        value = 12'h034;
        step();
        chk("snap_d1_old", {24'd0, seg_n}, {24'd0, 8'hF9});
        repeat (SLOT - 1) step();
        chk("snap_d2_old", {24'd0, seg_n}, {24'd0, 8'hC0});
        wait_tick(40, n);
        chk("snap_new_d0", {24'd0, seg_n}, {24'd0, 8'h99});
        repeat (SLOT) step();
        chk("snap_new_d1", {24'd0, seg_n}, {24'd0, 8'hB0});

        // en dropped for 3 cycles during digit 1.
        step();
        en = 1'b0;
        step();
        chk("en_low_dark", {20'd0, seg_n, an_n, frame_tick}, {20'd0, 8'hFF, 3'b111, 1'b0});
        step();
        step();
        en = 1'b1;
        wait_tick(40, n);
        chk("en_restart_tick", 32'(n), 32'(BC));
        chk("en_restart_d0", {24'd0, seg_n}, {24'd0, 8'hF9 & 8'h99 | 8'h99});

        // Asynchronous reset between edges during SHOW of digit 1.
        repeat (SLOT + 1) step();
        #2 reset = 1'b0;
        #1;
        chk("async_reset_dark", {20'd0, seg_n, an_n, frame_tick}, {20'd0, 8'hFF, 3'b111, 1'b0});
        model_reset();
        #2 reset = 1'b1;
        wait_tick(40, n);
        chk("tick_after_async_reset", 32'(n), 32'(BC));

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 3) == 0) value = 12'($urandom);
                else value = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                              4'($urandom_range(0, 9))};
                if ($urandom_range(0, 2) == 0) value[11:4] = 8'h00;
                dp_sel = 3'($urandom);
                lzb    = 1'($urandom);
            end
            if ($urandom_range(0, 99) == 0) en = 1'b0;
            else if (!en && $urandom_range(0, 2) == 0) en = 1'b1;
            if (c == 777) begin
                #3 reset = 1'b0;
                #1;
                chk("rand_async_reset", {21'd0, seg_n, an_n}, {21'd0, 8'hFF, 3'b111});
                model_reset();
                #2 reset = 1'b1;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
